// File: rtl/adpll_pi_loop_n.sv
// Programmable PI loop filter with hysteretic lock detector: signed phase error in, clamped DCO word out.
// One-cycle latency on err_valid; no backpressure, results hold between samples.
module adpll_pi_loop_n #(
  parameter int W   = 8,
  parameter int FW  = 10,
  parameter int LCW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  phase_err,
  input  logic          err_valid,
  input  logic          clr,
  input  logic          pgm,
  input  logic [2:0]    param_sel,
  input  logic [W-1:0]  pgm_value,
  input  logic [1:0]    out_sel,
  output logic [FW-1:0] dco_word,
  output logic [W-1:0]  dout,
  output logic          sign,
  output logic          locked,
  output logic          sat
);
  // Final sum carries one guard bit beyond FW+2 so a high F0 plus full integrator cannot wrap.
  localparam int SW = FW + 3;
  localparam logic [FW-1:0]         F0_DEF = {1'b1, {(FW-1){1'b0}}};
  localparam logic signed [FW+1:0]  IMAX   = {2'b00, {FW{1'b1}}};
  localparam logic signed [FW+1:0]  IMIN   = -IMAX;
  localparam logic signed [SW-1:0]  DMAX   = {3'b000, {FW{1'b1}}};
  localparam logic [FW:0]           MAGMAX = {{(FW+1-W){1'b0}}, {W{1'b1}}};

  typedef enum logic {ACQ, LOCK} state_t;

  state_t                state, state_n;
  logic [2:0]            kp, ki;
  logic [FW-1:0]         f0;
  logic [W-1:0]          lock_th;
  logic [LCW-1:0]        lock_n, cnt, cnt_n, cnt_inc;
  logic                  miss, miss_n;
  logic signed [FW:0]    integ, integ_n;
  logic signed [W-1:0]   prop, pe, prop_n, inc;
  logic signed [FW+1:0]  isum;
  logic signed [SW-1:0]  sum;
  logic [FW-1:0]         dco_n;
  logic                  sat_n, good, reach;
  logic [W-1:0]          mag, prop_abs;
  logic [FW:0]           integ_abs;

  assign pe     = phase_err;
  assign prop_n = pe >>> kp;
  assign inc    = pe >>> ki;
  assign isum   = {integ[FW], integ} + {{(FW+2-W){inc[W-1]}}, inc};

  always_comb begin
    integ_n = isum[FW:0];
    if (isum > IMAX)      integ_n = IMAX[FW:0];
    else if (isum < IMIN) integ_n = IMIN[FW:0];
  end

  assign sum = {3'b000, f0} + {{2{integ_n[FW]}}, integ_n} + {{(SW-W){prop_n[W-1]}}, prop_n};

  always_comb begin
    dco_n = sum[FW-1:0];
    sat_n = 1'b0;
    if (sum[SW-1]) begin
      dco_n = '0;
      sat_n = 1'b1;
    end else if (sum > DMAX) begin
      dco_n = '1;
      sat_n = 1'b1;
    end
  end

  // |phase_err| as unsigned W bits, so the most negative code maps to 2^(W-1).
  assign mag     = phase_err[W-1] ? (~phase_err) + W'(1) : phase_err;
  assign good    = mag <= lock_th;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + LCW'(1);
  assign reach   = ({1'b0, cnt} + (LCW+1)'(1)) >= {1'b0, lock_n};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    miss_n  = miss;
    case (state)
      ACQ: begin
        miss_n = 1'b0;
        if (good) begin
          cnt_n = cnt_inc;
          if (reach) state_n = LOCK;
        end else begin
          cnt_n = '0;
        end
      end
      LOCK: begin
        if (good) begin
          cnt_n  = cnt_inc;
          miss_n = 1'b0;
        end else if (miss) begin
          state_n = ACQ;
          cnt_n   = '0;
          miss_n  = 1'b0;
        end else begin
          cnt_n  = '0;
          miss_n = 1'b1;
        end
      end
      default: state_n = ACQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      kp       <= 3'd2;
      ki       <= 3'd4;
      f0       <= F0_DEF;
      lock_th  <= W'(2);
      lock_n   <= LCW'(8);
      integ    <= '0;
      prop     <= '0;
      dco_word <= F0_DEF;
      sat      <= 1'b0;
      cnt      <= '0;
      miss     <= 1'b0;
      state    <= ACQ;
    end else begin
      if (err_valid) begin
        integ    <= integ_n;
        prop     <= prop_n;
        dco_word <= dco_n;
        sat      <= sat_n;
        cnt      <= cnt_n;
        miss     <= miss_n;
        state    <= state_n;
      end
      // Parameter writes land after the same-cycle update, which already used the old values.
      if (pgm) begin
        case (param_sel)
          3'd0: kp      <= pgm_value[2:0];
          3'd1: ki      <= pgm_value[2:0];
          3'd2: f0      <= {pgm_value, {(FW-W){1'b0}}};
          3'd3: lock_th <= pgm_value;
          3'd4: lock_n  <= (pgm_value[LCW-1:0] == '0) ? LCW'(1) : pgm_value[LCW-1:0];
          default: ;
        endcase
      end
    end
  end

  assign locked    = (state == LOCK);
  assign integ_abs = integ[FW] ? $unsigned(-integ) : $unsigned(integ);
  assign prop_abs  = prop[W-1] ? (~prop) + W'(1) : prop;

  always_comb begin
    dout = '0;
    sign = 1'b0;
    case (out_sel)
      2'd0: dout = dco_word[FW-1:FW-W];
      2'd1: begin
        dout = (integ_abs > MAGMAX) ? '1 : integ_abs[W-1:0];
        sign = integ[FW];
      end
      2'd2: begin
        dout = prop_abs;
        sign = prop[W-1];
      end
      default: begin
        dout = {{(W-LCW){1'b0}}, cnt};
        sign = locked;
      end
    endcase
  end
endmodule

// File: tb/tb_adpll_pi_loop_n.sv
// Directed plus randomized bench for adpll_pi_loop_n against an integer reference model.
module tb_adpll_pi_loop_n;
  logic       clk = 1'b0;
  logic       rst_n, err_valid, clr, pgm, sign, locked, sat;
  logic [7:0] phase_err, pgm_value, dout;
  logic [2:0] param_sel;
  logic [1:0] out_sel;
  logic [9:0] dco_word;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_kp, m_ki, m_f0, m_th, m_ln, m_integ, m_prop, m_dco, m_sat, m_cnt, m_locked, m_miss;

  always #5 clk = ~clk;

  adpll_pi_loop_n #(.W(8), .FW(10), .LCW(6)) dut (
    .clk(clk), .rst_n(rst_n), .phase_err(phase_err), .err_valid(err_valid),
    .clr(clr), .pgm(pgm), .param_sel(param_sel), .pgm_value(pgm_value),
    .out_sel(out_sel), .dco_word(dco_word), .dout(dout), .sign(sign),
    .locked(locked), .sat(sat)
  );

  task automatic model_reset();
    m_kp = 2; m_ki = 4; m_f0 = 512; m_th = 2; m_ln = 8;
    m_integ = 0; m_prop = 0; m_dco = 512; m_sat = 0;
    m_cnt = 0; m_locked = 0; m_miss = 0;
  endtask

  task automatic model_update(input bit c, input bit p, input int sel, input int val,
                              input bit ev, input int pe);
    int s, mag;
    bit ok;
    if (c) begin
      model_reset();
      return;
    end
    if (ev) begin
      m_prop  = pe >>> m_kp;
      m_integ = m_integ + (pe >>> m_ki);
      if (m_integ > 1023)  m_integ = 1023;
      if (m_integ < -1023) m_integ = -1023;
      s = m_f0 + m_integ + m_prop;
      m_sat = (s < 0 || s > 1023) ? 1 : 0;
      m_dco = (s < 0) ? 0 : (s > 1023) ? 1023 : s;
      mag = (pe < 0) ? -pe : pe;
      ok  = (mag <= m_th);
      if (!m_locked) begin
        m_miss = 0;
        if (ok) begin
          if (m_cnt + 1 >= m_ln) m_locked = 1;
          m_cnt = (m_cnt == 63) ? 63 : m_cnt + 1;
        end else m_cnt = 0;
      end else if (ok) begin
        m_cnt = (m_cnt == 63) ? 63 : m_cnt + 1;
        m_miss = 0;
      end else if (m_miss == 1) begin
        m_locked = 0; m_cnt = 0; m_miss = 0;
      end else begin
        m_miss = 1; m_cnt = 0;
      end
    end
    if (p) begin
      case (sel)
        0: m_kp = val & 7;
        1: m_ki = val & 7;
        2: m_f0 = val * 4;
        3: m_th = val;
        4: m_ln = ((val & 63) == 0) ? 1 : (val & 63);
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int ed, es, a;
    chk({tag, ".dco"},    32'(dco_word), 32'(m_dco));
    chk({tag, ".sat"},    32'(sat),      32'(m_sat));
    chk({tag, ".locked"}, 32'(locked),   32'(m_locked));
    for (int s = 0; s < 4; s++) begin
      out_sel = 2'(s);
      #1;
      case (s)
        0: begin ed = m_dco / 4; es = 0; end
        1: begin a = (m_integ < 0) ? -m_integ : m_integ; ed = (a > 255) ? 255 : a; es = (m_integ < 0); end
        2: begin ed = (m_prop < 0) ? -m_prop : m_prop; es = (m_prop < 0); end
        default: begin ed = m_cnt; es = m_locked; end
      endcase
      chk($sformatf("%s.dout%0d", tag, s), 32'(dout), 32'(ed));
      chk($sformatf("%s.sign%0d", tag, s), 32'(sign), 32'(es));
    end
    out_sel = 2'd0;
  endtask

  task automatic step(input string tag, input bit c, input bit p, input int sel,
                      input int val, input bit ev, input int pe);
    clr = c; pgm = p; param_sel = 3'(sel); pgm_value = 8'(val);
    err_valid = ev; phase_err = 8'(pe);
    @(posedge clk);
    model_update(c, p, sel, val, ev, pe);
    @(negedge clk);
    clr = 1'b0; pgm = 1'b0; err_valid = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int pe, val, sel;
    bit c, p, ev;
    rst_n = 1'b0; err_valid = 1'b0; clr = 1'b0; pgm = 1'b0;
    param_sel = 3'd0; pgm_value = 8'd0; phase_err = 8'd0; out_sel = 2'd0;
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);
    check_all("reset");

    step("pe16", 0, 0, 0, 0, 1, 16);

    step("pgm_ki0", 0, 1, 1, 0, 0, 0);
    step("pgm_kp7", 0, 1, 0, 7, 0, 0);
    for (int i = 0; i < 6; i++) step($sformatf("pos%0d", i), 0, 0, 0, 0, 1, 127);
    for (int i = 0; i < 16; i++) step($sformatf("neg%0d", i), 0, 0, 0, 0, 1, -128);

    for (int i = 0; i < 8; i++) step($sformatf("lock%0d", i), 0, 0, 0, 0, 1, 1);
    step("miss1", 0, 0, 0, 0, 1, 10);
    step("hit", 0, 0, 0, 0, 1, 1);
    step("missa", 0, 0, 0, 0, 1, 10);
    step("missb", 0, 0, 0, 0, 1, 10);

    step("f0_same", 0, 1, 2, 8'h40, 1, 0);
    step("f0_next", 0, 0, 0, 0, 1, 0);
    step("rsvd6", 0, 1, 6, 8'hA5, 0, 0);
    step("rsvd6_s", 0, 0, 0, 0, 1, 3);

    for (int i = 0; i < 8; i++) step($sformatf("relock%0d", i), 0, 0, 0, 0, 1, 2);
    step("clr_ev", 1, 0, 0, 0, 1, 100);
    step("post_clr", 0, 0, 0, 0, 1, 16);

    for (int i = 0; i < 5; i++) step($sformatf("pre_rst%0d", i), 0, 0, 0, 0, 1, -40);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.dco",    32'(dco_word), 32'(m_dco));
    chk("arst.locked", 32'(locked),   32'(m_locked));
    chk("arst.sat",    32'(sat),      32'(m_sat));
    chk("arst.dout",   32'(dout),     32'd128);
    @(negedge clk);
    rst_n = 1'b1;
    check_all("arst_hold");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) pe = int'($urandom_range(0, 6)) - 3;
      else                            pe = int'($urandom_range(0, 255)) - 128;
      c   = ($urandom_range(0, 39) == 0);
      p   = ($urandom_range(0, 7) == 0);
      ev  = ($urandom_range(0, 3) != 0);
      sel = int'($urandom_range(0, 7));
      val = int'($urandom_range(0, 255));
      if (sel == 3) val = val & 7;
      step($sformatf("rnd%0d", i), c, p, sel, val, ev, pe);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
